reg_file: RTL
=============

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameters SHALL be: NUM_REGS, 32, number of architectural registers; DATA_W, 32, register width in bits.
REQ-002 clk  input  1  single pipeline clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rfWriteEn_p0  input  1  write strobe from the writeback stage (its done_out, qualified for non-store ops).
REQ-005 rfWriteAddr_p0  input  5  destination register of the write.
REQ-006 rfWriteData_p0  input  DATA_W  data to write.
REQ-007 done_in  input  1  decode read request; operands are requested this cycle.
REQ-008 rdAddrA, rdAddrB  input  5 each  source register addresses (rs, rt).
REQ-009 sbSetEn, sbSetAddr  input  1, 5  decode marks a destination register as pending-write.
REQ-010 rdDataA, rdDataB  output  DATA_W each  registered operand data.
REQ-011 done_out  output  1  operands valid this cycle.
REQ-012 stall  output  1  combinational; a requested source register has a pending write.

Function
REQ-013 A write SHALL occur at the clock edge where rfWriteEn_p0=1 and rfWriteAddr_p0!=0; writes to register 0 SHALL be discarded.
REQ-014 Register 0 SHALL always read as 0.
REQ-015 Read latency SHALL be one cycle: with done_in=1 and stall=0 at edge N, rdDataA/rdDataB SHALL hold the addressed contents and done_out=1 after edge N.
REQ-016 If done_in=0 or stall=1 at edge N, done_out SHALL be 0 after edge N, and rdDataA/rdDataB SHALL hold their previous values.
REQ-017 Scoreboard: one pending bit per register; sbSetEn=1 SHALL set pending[sbSetAddr] (ignored for address 0). Any accepted write (REQ-013) SHALL clear pending[rfWriteAddr_p0].
REQ-018 If a set and a clear target the same register in the same cycle, set SHALL win, because the set belongs to the younger instruction.
REQ-019 stall SHALL be done_in AND (pending[rdAddrA] OR pending[rdAddrB]), after applying the REQ-023 exception; address 0 SHALL never stall.
REQ-020 Every read SHALL return the pre-edge contents when there is no bypass, including the same-cycle write case (REQ-024).
REQ-021 rdAddrA==rdAddrB SHALL return identical data on both ports.

Reset
REQ-022 While rst_n=0: all registers SHALL be 0, all pending bits 0, rdDataA/rdDataB 0, done_out 0. Deassertion SHALL take effect at the next rising edge. Reset mid-operation SHALL discard any in-flight read.

Configuration
REQ-023 With macro RF_BYPASS_EN defined: a same-cycle write whose rfWriteAddr_p0 matches a nonzero read address SHALL supply rfWriteData_p0 as that port's read data. In that same cycle the write's pending bit SHALL NOT cause stall for that address.
REQ-024 Without RF_BYPASS_EN: the read SHALL return the old contents, and stall SHALL reflect the pending bit before the clear.

Structure
REQ-025 The shared structures package SHALL hold RF_ADDR_W=5, REG_ZERO=5'd0 and the instr_structure typedef used by decode and writeback; reg_file SHALL NOT redefine them.
REQ-026 Scoreboard logic SHALL be one sub-module, rf_scoreboard (set/clear/query, 32 bits); the storage array and read pipeline SHALL stay in reg_file.

Verification
REQ-027 Write r5=32'hDEADBEEF, then read A=5, B=0 with done_in=1 -> next cycle rdDataA=DEADBEEF, rdDataB=0, done_out=1.
REQ-028 Write r0=32'h1234, then read A=0 -> rdDataA=0; pending[0] is never set.
REQ-029 sbSetEn for r7, then read A=7 -> stall=1 and done_out=0 next cycle; write r7=42, then read -> rdDataA=42, stall=0.
REQ-030 Write r9=100 and read A=9 in the same cycle, with r9 previously 3 -> rdDataA=100 with RF_BYPASS_EN, 3 without it.
REQ-031 sbSetEn r4 and write r4=8 in the same cycle -> pending[4] stays 1, and a read of r4 the next cycle stalls.
REQ-032 Assert rst_n=0 after writing r1=77, mid-read -> done_out=0 and rdDataA=0 immediately; a read of r1 after release returns 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared register-file types: address width, zero register, instruction bundle.
// Used by decode, writeback and reg_file; optional macro RF_BYPASS_EN lives in reg_file.
package reg_file_pkg;

   localparam int RF_ADDR_W = 5;
   localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      OP_ALU,
      OP_LOAD,
      OP_STORE,
      OP_BRANCH
   } op_class_e;

   typedef struct packed {
      op_class_e            op;
      logic [RF_ADDR_W-1:0] rs;
      logic [RF_ADDR_W-1:0] rt;
      logic [RF_ADDR_W-1:0] rd;
      logic [15:0]          imm;
   } instr_structure;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by decode, cleared by writeback.
// A set and a clear to the same register in one cycle leaves the bit set.
module rf_scoreboard
   import reg_file_pkg::*;
#(
   parameter int NUM_REGS = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 set_en,
   input  logic [RF_ADDR_W-1:0] set_addr,
   input  logic                 clr_en,
   input  logic [RF_ADDR_W-1:0] clr_addr,
   input  logic [RF_ADDR_W-1:0] qry_a,
   input  logic [RF_ADDR_W-1:0] qry_b,
   output logic                 pend_a,
   output logic                 pend_b
);

   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pend_nxt;

   // Clear first, then set, so the younger instruction's claim wins.
   always_comb begin
      pend_nxt = pending;
      if (clr_en)
         pend_nxt[clr_addr] = 1'b0;
      if (set_en && set_addr != REG_ZERO)
         pend_nxt[set_addr] = 1'b1;
      pend_nxt[0] = 1'b0;
   end

   // Pending-bit register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pending <= '0;
      else
         pending <= pend_nxt;
   end

   assign pend_a = pending[qry_a] & (qry_a != REG_ZERO);
   assign pend_b = pending[qry_b] & (qry_b != REG_ZERO);

endmodule

// File: rtl/reg_file.sv
// Register file with registered two-port read and pending-write stall.
// Define RF_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int DATA_W   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rfWriteEn_p0,
   input  logic [RF_ADDR_W-1:0] rfWriteAddr_p0,
   input  logic [DATA_W-1:0]    rfWriteData_p0,
   input  logic                 done_in,
   input  logic [RF_ADDR_W-1:0] rdAddrA,
   input  logic [RF_ADDR_W-1:0] rdAddrB,
   input  logic                 sbSetEn,
   input  logic [RF_ADDR_W-1:0] sbSetAddr,
   output logic [DATA_W-1:0]    rdDataA,
   output logic [DATA_W-1:0]    rdDataB,
   output logic                 done_out,
   output logic                 stall
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   logic              wr_ok;
   logic              pend_a;
   logic              pend_b;
   logic              byp_a;
   logic              byp_b;
   logic              rd_go;
   logic [DATA_W-1:0] val_a;
   logic [DATA_W-1:0] val_b;

   assign wr_ok = rfWriteEn_p0 && (rfWriteAddr_p0 != REG_ZERO);

   rf_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (sbSetEn),
      .set_addr (sbSetAddr),
      .clr_en   (wr_ok),
      .clr_addr (rfWriteAddr_p0),
      .qry_a    (rdAddrA),
      .qry_b    (rdAddrB),
      .pend_a   (pend_a),
      .pend_b   (pend_b)
   );

`ifdef RF_BYPASS_EN
   assign byp_a = wr_ok && (rfWriteAddr_p0 == rdAddrA);
   assign byp_b = wr_ok && (rfWriteAddr_p0 == rdAddrB);
`else
   assign byp_a = 1'b0;
   assign byp_b = 1'b0;
`endif

   // A bypassed write satisfies its own pending bit.
   assign stall = done_in &
                  ((pend_a & ~byp_a) | (pend_b & ~byp_b));

   assign rd_go = done_in & ~stall;

   // Operand select: zero register, forwarded write, or stored value.
   always_comb begin
      val_a = regs[rdAddrA];
      val_b = regs[rdAddrB];
      if (byp_a)
         val_a = rfWriteData_p0;
      if (byp_b)
         val_b = rfWriteData_p0;
      if (rdAddrA == REG_ZERO)
         val_a = '0;
      if (rdAddrB == REG_ZERO)
         val_b = '0;
   end

   // Storage array; register 0 is never written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (wr_ok) begin
         regs[rfWriteAddr_p0] <= rfWriteData_p0;
      end
   end

   // Read pipeline register; operands hold when no read is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdDataA  <= '0;
         rdDataB  <= '0;
         done_out <= 1'b0;
      end else begin
         done_out <= rd_go;
         if (rd_go) begin
            rdDataA <= val_a;
            rdDataB <= val_b;
         end
      end
   end

endmodule
